// File: rtl/dm_ctrl_pkg.sv
// rtl/dm_ctrl_pkg.sv - shared types, constants and byte-merge helper for the data-memory controller
package dm_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RMW    = 2'd2,
        RESP   = 2'd3
    } dm_state_e;

    localparam logic       P_CPU   = 1'b0;
    localparam logic       P_DMA   = 1'b1;
    localparam logic [3:0] BE_FULL = 4'hF;
    localparam int         NPORT   = 2;

    // Byte k comes from new_word when be[k] is set, otherwise from old_word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] new_word,
                                                input logic [31:0] old_word,
                                                input logic [3:0]  be);
        logic [31:0] res;
        for (int k = 0; k < 4; k++) begin
            res[8*k +: 8] = be[k] ? new_word[8*k +: 8] : old_word[8*k +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dm_rr_arb.sv
// rtl/dm_rr_arb.sv - combinational 2-way round-robin picker; last_grant is stored by the caller
module dm_rr_arb (
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_grant_i,
    output logic gnt_valid_o,
    output logic gnt_id_o
);

    always_comb begin
        gnt_valid_o = req0_i | req1_i;
        if (req0_i && req1_i) begin
            gnt_id_o = ~last_grant_i;
        end else begin
            gnt_id_o = req1_i;
        end
    end

endmodule

// File: rtl/dm_ctrl.sv
// rtl/dm_ctrl.sv - two-port data-memory access controller with RMW for partial stores
// Optional write trace compiled in when DM_CTRL_TRACE_EN is defined.
module dm_ctrl
    import dm_ctrl_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req0_i,
    input  logic        req1_i,
    input  logic        we0_i,
    input  logic        we1_i,
    input  logic [31:0] addr0_i,
    input  logic [31:0] addr1_i,
    input  logic [31:0] wdata0_i,
    input  logic [31:0] wdata1_i,
    input  logic [3:0]  be0_i,
    input  logic [3:0]  be1_i,
    output logic        ack0_o,
    output logic        ack1_o,
    output logic [31:0] rdata_o,
    output logic        busy_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    output logic        mem_we_o,
    input  logic [31:0] mem_rd_i
);

    dm_state_e   state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        id_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [31:0] rdata_q;
    logic [31:0] merge_q;

    logic        gnt_valid;
    logic        gnt_id;
    logic        accept;
    logic        cap_rdata;
    logic        cap_merge;

    dm_rr_arb u_arb (
        .req0_i       (req0_i),
        .req1_i       (req1_i),
        .last_grant_i (last_grant_q),
        .gnt_valid_o  (gnt_valid),
        .gnt_id_o     (gnt_id)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        accept       = 1'b0;
        cap_rdata    = 1'b0;
        cap_merge    = 1'b0;
        mem_we_o     = 1'b0;
        mem_wd_o     = 32'h0;
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    accept       = 1'b1;
                    last_grant_d = gnt_id;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                state_d = RESP;
                if (!we_q) begin
                    cap_rdata = 1'b1;
                end else if (be_q == BE_FULL) begin
                    mem_we_o = 1'b1;
                    mem_wd_o = wdata_q;
                end else if (be_q != 4'h0) begin
                    cap_merge = 1'b1;
                    state_d   = RMW;
                end
            end
            RMW: begin
                mem_we_o = 1'b1;
                mem_wd_o = merge_bytes(wdata_q, merge_q, be_q);
                state_d  = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            last_grant_q <= P_DMA;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Request fields are latched once at grant so a requester that
    // misbehaves mid-access cannot corrupt the transfer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            id_q    <= P_CPU;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            be_q    <= 4'h0;
            rdata_q <= 32'h0;
            merge_q <= 32'h0;
        end else begin
            if (accept) begin
                id_q    <= gnt_id;
                we_q    <= gnt_id ? we1_i : we0_i;
                addr_q  <= (gnt_id ? addr1_i : addr0_i) & 32'hFFFF_FFFC;
                wdata_q <= gnt_id ? wdata1_i : wdata0_i;
                be_q    <= gnt_id ? be1_i : be0_i;
            end
            if (cap_rdata) begin
                rdata_q <= mem_rd_i;
            end
            if (cap_merge) begin
                merge_q <= mem_rd_i;
            end
        end
    end

    assign mem_addr_o = {addr_q[31:ADDR_W+2], addr_q[ADDR_W+1:0]};
    assign rdata_o    = rdata_q;
    assign busy_o     = (state_q != IDLE);
    assign ack0_o     = (state_q == RESP) && (id_q == P_CPU);
    assign ack1_o     = (state_q == RESP) && (id_q == P_DMA);

`ifdef DM_CTRL_TRACE_EN
    always @(posedge clk_i) begin
        if (mem_we_o) begin
            $display("%0t@%0d: *%h <= %h", $time, id_q, mem_addr_o, mem_wd_o);
        end
    end
`endif

endmodule

// File: tb/tb_dm_ctrl.sv
// tb/tb_dm_ctrl.sv - scoreboard bench for dm_ctrl with a behavioural 1024x32 memory
module tb_dm_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [3:0]  be0, be1;
    logic        ack0, ack1, busy, mem_we;
    logic [31:0] rdata, mem_addr, mem_wd, mem_rd;

    logic [31:0] mem [0:1023];

    typedef struct {
        logic        port;
        int          cyc;
        logic [31:0] rdata;
        logic        is_rd;
    } exp_t;

    exp_t        sb_q[$];
    int          cyc;
    int          pass_cnt;
    int          total_cnt;
    int          we_cnt;
    int          last_we_cyc;
    logic [31:0] last_we_addr;

    dm_ctrl #(.ADDR_W(10)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .req0_i     (req0),
        .req1_i     (req1),
        .we0_i      (we0),
        .we1_i      (we1),
        .addr0_i    (addr0),
        .addr1_i    (addr1),
        .wdata0_i   (wdata0),
        .wdata1_i   (wdata1),
        .be0_i      (be0),
        .be1_i      (be1),
        .ack0_o     (ack0),
        .ack1_o     (ack1),
        .rdata_o    (rdata),
        .busy_o     (busy),
        .mem_addr_o (mem_addr),
        .mem_wd_o   (mem_wd),
        .mem_we_o   (mem_we),
        .mem_rd_i   (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rd = mem[mem_addr[11:2]];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[11:2]] <= mem_wd;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (mem_we) begin
            we_cnt++;
            last_we_cyc  = cyc;
            last_we_addr = mem_addr;
        end
        if (ack0 || ack1) begin
            chk("ack_exclusive", {31'h0, ack0 & ack1}, 32'h0);
            if (sb_q.size() == 0) begin
                chk("unexpected_ack", {31'h0, ack1}, {31'h0, ~ack1});
            end else begin
                e = sb_q.pop_front();
                chk("ack_port", {31'h0, ack1}, {31'h0, e.port});
                chk("ack_cycle", cyc, e.cyc);
                if (e.is_rd) chk("rdata", rdata, e.rdata);
            end
        end
    end

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (busy) chk("idle_timeout", {31'h0, busy}, 32'h0);
    endtask

    task automatic drive(input logic p, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be);
        if (p) begin
            req1 = 1'b1; we1 = we; addr1 = a; wdata1 = wd; be1 = be;
        end else begin
            req0 = 1'b1; we0 = we; addr0 = a; wdata0 = wd; be0 = be;
        end
    endtask

    task automatic issue(input logic p, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be,
                         input int lat, input logic [31:0] rd, output int n);
        bit got = 0;
        wait_idle();
        @(negedge clk);
        n = cyc;
        drive(p, we, a, wd, be);
        sb_q.push_back('{port: p, cyc: n + lat, rdata: rd, is_rd: !we});
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (p ? ack1 : ack0) begin
                got = 1;
                break;
            end
        end
        if (!got) chk("ack_timeout", 32'h0, 32'h1);
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic drain_pair();
        int c0 = 0, c1 = 0;
        for (int i = 0; i < 30 && (req0 || req1); i++) begin
            @(negedge clk);
            if (ack0) begin
                c0++;
                if (c0 == 1 && cyc < 0) req0 = 1'b0;
            end
            if (ack1) c1++;
            if (ack0 && c0 >= 2) req0 = 1'b0;
            if (ack1 && c1 >= 2) req1 = 1'b0;
            if (ack0 && c0 == 1) drive(1'b0, 1'b0, 32'h20, 32'h0, 4'h0);
            if (ack1 && c1 == 1) drive(1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
        end
        if (req0 || req1) chk("pair_timeout", {30'h0, req1, req0}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int w0;
        cyc = 0; pass_cnt = 0; total_cnt = 0; we_cnt = 0; last_we_cyc = -1; last_we_addr = 32'h0;
        rst_n = 1'b0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0; be0 = 0; be1 = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[4]  = 32'hDEADBEEF;
        mem[3]  = 32'hAABBCCDD;
        mem[12] = 32'h55556666;
        mem[5]  = 32'h01020304;

        @(negedge clk); @(negedge clk);
        chk("rst_ack0", {31'h0, ack0}, 32'h0);
        chk("rst_ack1", {31'h0, ack1}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wd", mem_wd, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Port 0 read
        w0 = we_cnt;
        issue(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 2, 32'hDEADBEEF, n);
        chk("rd_no_we", we_cnt - w0, 32'h0);

        // Port 1 full-word write
        w0 = we_cnt;
        issue(1'b1, 1'b1, 32'h20, 32'h12345678, 4'hF, 2, 32'h0, n);
        chk("full_we_count", we_cnt - w0, 32'h1);
        chk("full_we_cycle", last_we_cyc, n + 1);
        chk("full_we_addr", last_we_addr, 32'h20);
        chk("full_mem", mem[8], 32'h12345678);

        // Port 0 byte store via read-modify-write
        w0 = we_cnt;
        issue(1'b0, 1'b1, 32'h0E, 32'h00EE0000, 4'b0100, 3, 32'h0, n);
        chk("sb_we_count", we_cnt - w0, 32'h1);
        chk("sb_we_cycle", last_we_cyc, n + 2);
        chk("sb_mem", mem[3], 32'hAAEECCDD);

        // Zero byte-enable write
        w0 = we_cnt;
        issue(1'b1, 1'b1, 32'h30, 32'hFFFFFFFF, 4'h0, 2, 32'h0, n);
        chk("be0_we_count", we_cnt - w0, 32'h0);
        chk("be0_mem", mem[12], 32'h55556666);

        // Contention: both ports continuously requesting, expect 0,1,0,1
        wait_idle();
        @(negedge clk);
        n = cyc;
        drive(1'b0, 1'b0, 32'h10, 32'h0, 4'h0);
        drive(1'b1, 1'b1, 32'h40, 32'h11112222, 4'hF);
        sb_q.push_back('{port: 1'b0, cyc: n + 2,  rdata: 32'hDEADBEEF, is_rd: 1'b1});
        sb_q.push_back('{port: 1'b1, cyc: n + 5,  rdata: 32'h0,        is_rd: 1'b0});
        sb_q.push_back('{port: 1'b0, cyc: n + 8,  rdata: 32'h12345678, is_rd: 1'b1});
        sb_q.push_back('{port: 1'b1, cyc: n + 11, rdata: 32'h11112222, is_rd: 1'b1});
        drain_pair();
        chk("rr_mem", mem[16], 32'h11112222);

        // Reset during RMW of a halfword store
        wait_idle();
        @(negedge clk);
        drive(1'b0, 1'b1, 32'h14, 32'hFFFFFFFF, 4'b0011);
        @(negedge clk);
        @(negedge clk);
        chk("rmw_we_before_rst", {31'h0, mem_we}, 32'h1);
        rst_n = 1'b0;
        req0  = 1'b0;
        #1;
        chk("rmw_rst_we", {31'h0, mem_we}, 32'h0);
        chk("rmw_rst_busy", {31'h0, busy}, 32'h0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        chk("rmw_rst_mem", mem[5], 32'h01020304);
        @(negedge clk);
        chk("post_rst_ack", {30'h0, ack1, ack0}, 32'h0);
        chk("post_rst_busy", {31'h0, busy}, 32'h0);

        // First contention after reset must favour port 0
        @(negedge clk);
        n = cyc;
        drive(1'b0, 1'b0, 32'h10, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        sb_q.push_back('{port: 1'b0, cyc: n + 2, rdata: 32'hDEADBEEF, is_rd: 1'b1});
        sb_q.push_back('{port: 1'b1, cyc: n + 5, rdata: 32'h12345678, is_rd: 1'b1});
        for (int i = 0; i < 20 && (req0 || req1); i++) begin
            @(negedge clk);
            if (ack0) req0 = 1'b0;
            if (ack1) req1 = 1'b0;
        end
        if (req0 || req1) chk("post_rst_timeout", {30'h0, req1, req0}, 32'h0);

        repeat (3) @(negedge clk);
        chk("sb_drained", sb_q.size(), 32'h0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
